// File: rtl/systolic_pkg.sv
// Shared Q8.8 fixed-point definitions for the 2x2 weight-stationary array.
package systolic_pkg;
    localparam int DATA_W = 16;
    localparam int FRAC_W = 8;

    typedef logic signed [DATA_W-1:0] fixed16_t;
endpackage

// File: rtl/systolic_pe.sv
// Single weight-stationary cell: shadow/active weight pair, Q8.8 MAC, and
// one register stage for everything moving right (data/valid/switch) or down.
module systolic_pe #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int FRAC_W = systolic_pkg::FRAC_W
) (
    input  logic                     i_clk,
    input  logic                     i_rst_n,
    input  logic signed [DATA_W-1:0] i_data,
    input  logic                     i_valid,
    input  logic                     i_switch,
    input  logic signed [DATA_W-1:0] i_weight,
    input  logic                     i_accept,
    input  logic signed [DATA_W-1:0] i_psum,
    output logic signed [DATA_W-1:0] o_data,
    output logic                     o_valid,
    output logic                     o_switch,
    output logic signed [DATA_W-1:0] o_weight,
    output logic                     o_accept,
    output logic signed [DATA_W-1:0] o_psum
);

    logic signed [DATA_W-1:0]   r_shadow;
    logic signed [DATA_W-1:0]   r_active;
    logic signed [DATA_W-1:0]   r_weight_out;
    logic signed [DATA_W-1:0]   r_data_out;
    logic signed [DATA_W-1:0]   r_psum_out;
    logic                       r_valid_out;
    logic                       r_switch_out;
    logic                       r_accept_out;

    logic signed [DATA_W-1:0]   w_weight_eff;
    logic signed [2*DATA_W-1:0] w_prod;
    logic signed [DATA_W-1:0]   w_prod_q;

    // Bypass lets the first vector issued with a swap already use the new weight.
    assign w_weight_eff = i_switch ? r_shadow : r_active;
    assign w_prod       = (2*DATA_W)'(i_data) * (2*DATA_W)'(w_weight_eff);
    assign w_prod_q     = DATA_W'(w_prod >>> FRAC_W);

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_shadow     <= '0;
            r_active     <= '0;
            r_weight_out <= '0;
            r_data_out   <= '0;
            r_psum_out   <= '0;
            r_valid_out  <= 1'b0;
            r_switch_out <= 1'b0;
            r_accept_out <= 1'b0;
        end else begin
            r_data_out   <= i_data;
            r_valid_out  <= i_valid;
            r_switch_out <= i_switch;
            r_accept_out <= i_accept;
            if (i_accept) begin
                r_shadow     <= i_weight;
                r_weight_out <= r_shadow;
            end
            if (i_switch) begin
                r_active <= r_shadow;
            end
            r_psum_out <= i_valid ? (i_psum + w_prod_q) : '0;
        end
    end

    assign o_data   = r_data_out;
    assign o_valid  = r_valid_out;
    assign o_switch = r_switch_out;
    assign o_weight = r_weight_out;
    assign o_accept = r_accept_out;
    assign o_psum   = r_psum_out;

endmodule

// File: rtl/systolic.sv
// 2x2 weight-stationary systolic array: four PEs with right-moving activations
// and down-moving weights/partial sums; row 2 runs one cycle behind row 1.
module systolic #(
    parameter int DATA_W = systolic_pkg::DATA_W,
    parameter int FRAC_W = systolic_pkg::FRAC_W
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] sys_data_in_11,
    input  logic [DATA_W-1:0] sys_data_in_21,
    input  logic              sys_start,
    input  logic [DATA_W-1:0] sys_weight_in_11,
    input  logic [DATA_W-1:0] sys_weight_in_12,
    input  logic              sys_accept_w_1,
    input  logic              sys_accept_w_2,
    input  logic              sys_switch_in,
    output logic [DATA_W-1:0] sys_data_out_21,
    output logic [DATA_W-1:0] sys_data_out_22,
    output logic              sys_valid_out_21,
    output logic              sys_valid_out_22
);

    logic [DATA_W-1:0] w_data_11, w_weight_11, w_psum_11;
    logic              w_valid_11, w_switch_11, w_accept_11;
    logic [DATA_W-1:0] w_weight_12, w_psum_12;
    logic              w_accept_12;
    logic [DATA_W-1:0] w_data_21;
    logic              w_valid_21, w_switch_21;

    logic [DATA_W-1:0] w_unused_data_12, w_unused_weight_21;
    logic [DATA_W-1:0] w_unused_data_22, w_unused_weight_22;
    logic              w_unused_valid_12, w_unused_switch_12;
    logic              w_unused_accept_21, w_unused_switch_22, w_unused_accept_22;

    systolic_pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_pe11 (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_data   (sys_data_in_11),
        .i_valid  (sys_start),
        .i_switch (sys_switch_in),
        .i_weight (sys_weight_in_11),
        .i_accept (sys_accept_w_1),
        .i_psum   ('0),
        .o_data   (w_data_11),
        .o_valid  (w_valid_11),
        .o_switch (w_switch_11),
        .o_weight (w_weight_11),
        .o_accept (w_accept_11),
        .o_psum   (w_psum_11)
    );

    systolic_pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_pe12 (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_data   (w_data_11),
        .i_valid  (w_valid_11),
        .i_switch (w_switch_11),
        .i_weight (sys_weight_in_12),
        .i_accept (sys_accept_w_2),
        .i_psum   ('0),
        .o_data   (w_unused_data_12),
        .o_valid  (w_unused_valid_12),
        .o_switch (w_unused_switch_12),
        .o_weight (w_weight_12),
        .o_accept (w_accept_12),
        .o_psum   (w_psum_12)
    );

    // Row 2 reuses PE11's delayed valid/switch, giving the one-cycle row skew.
    systolic_pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_pe21 (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_data   (sys_data_in_21),
        .i_valid  (w_valid_11),
        .i_switch (w_switch_11),
        .i_weight (w_weight_11),
        .i_accept (w_accept_11),
        .i_psum   (w_psum_11),
        .o_data   (w_data_21),
        .o_valid  (w_valid_21),
        .o_switch (w_switch_21),
        .o_weight (w_unused_weight_21),
        .o_accept (w_unused_accept_21),
        .o_psum   (sys_data_out_21)
    );

    systolic_pe #(.DATA_W(DATA_W), .FRAC_W(FRAC_W)) u_pe22 (
        .i_clk    (clk),
        .i_rst_n  (rst),
        .i_data   (w_data_21),
        .i_valid  (w_valid_21),
        .i_switch (w_switch_21),
        .i_weight (w_weight_12),
        .i_accept (w_accept_12),
        .i_psum   (w_psum_12),
        .o_data   (w_unused_data_22),
        .o_valid  (sys_valid_out_22),
        .o_switch (w_unused_switch_22),
        .o_weight (w_unused_weight_22),
        .o_accept (w_unused_accept_22),
        .o_psum   (sys_data_out_22)
    );

    assign sys_valid_out_21 = w_valid_21;

endmodule

// File: tb/tb_systolic.sv
// Directed bench for the 2x2 systolic array with hand-computed Q8.8 results.
module tb_systolic;
    import systolic_pkg::*;

    localparam fixed16_t ONE   = 16'h0100;
    localparam fixed16_t TWO   = 16'h0200;
    localparam fixed16_t HALF  = 16'h0080;
    localparam fixed16_t MONE  = 16'hFF00;
    localparam fixed16_t MHALF = 16'hFF80;

    logic        clk;
    logic        rst;
    logic [15:0] d11, d21, wi11, wi12;
    logic        start, acc1, acc2, sw;
    logic [15:0] o21, o22;
    logic        v21, v22;

    int checks = 0;
    int errors = 0;

    systolic dut (
        .clk              (clk),
        .rst              (rst),
        .sys_data_in_11   (d11),
        .sys_data_in_21   (d21),
        .sys_start        (start),
        .sys_weight_in_11 (wi11),
        .sys_weight_in_12 (wi12),
        .sys_accept_w_1   (acc1),
        .sys_accept_w_2   (acc2),
        .sys_switch_in    (sw),
        .sys_data_out_21  (o21),
        .sys_data_out_22  (o22),
        .sys_valid_out_21 (v21),
        .sys_valid_out_22 (v22)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [15:0] obs, input logic [15:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic drv(input logic [15:0] a, input logic s, input logic [15:0] b, input logic w);
        d11   = a;
        start = s;
        d21   = b;
        sw    = w;
    endtask

    // Bottom-row weight goes in first, top-row weight one cycle later.
    task automatic load_w(input logic [15:0] w11, input logic [15:0] w12,
                          input logic [15:0] w21, input logic [15:0] w22);
        wi11 = w21; wi12 = w22; acc1 = 1'b1; acc2 = 1'b1;
        step();
        wi11 = w11; wi12 = w12;
        step();
        wi11 = '0; wi12 = '0; acc1 = 1'b0; acc2 = 1'b0;
        step();
    endtask

    task automatic swap_only();
        drv('0, 1'b0, '0, 1'b1);
        step();
        drv('0, 1'b0, '0, 1'b0);
    endtask

    initial begin
        rst = 1'b0;
        d11 = '0; d21 = '0; wi11 = '0; wi12 = '0;
        start = 1'b0; acc1 = 1'b0; acc2 = 1'b0; sw = 1'b0;
        #2;
        chk("rst_o21", o21, 16'h0000);
        chk("rst_v21", v21, 1'b0);
        chk("rst_o22", o22, 16'h0000);
        chk("rst_v22", v22, 1'b0);
        step(); step();
        rst = 1'b1;
        step();
        chk("idle_v21", v21, 1'b0);

        // Identity weights, vectors (1,2) then (3,4)
        load_w(ONE, '0, '0, ONE);
        swap_only();
        drv(ONE, 1'b1, '0, 1'b0);        step();
        drv(16'h0300, 1'b1, TWO, 1'b0);  step();
        chk("id_o21_a", o21, 16'h0100);
        chk("id_v21_a", v21, 1'b1);
        chk("id_v22_pre", v22, 1'b0);
        drv('0, 1'b0, 16'h0400, 1'b0);   step();
        chk("id_o21_b", o21, 16'h0300);
        chk("id_o22_a", o22, 16'h0200);
        chk("id_v22_a", v22, 1'b1);
        drv('0, 1'b0, '0, 1'b0);         step();
        chk("id_o22_b", o22, 16'h0400);
        chk("id_v21_end", v21, 1'b0);
        chk("id_o21_end", o21, 16'h0000);
        step();
        chk("id_v22_end", v22, 1'b0);

        // Mixed weights [[0.5,2],[-1,1]], vector (1,2)
        load_w(HALF, TWO, MONE, ONE);
        swap_only();
        drv(ONE, 1'b1, '0, 1'b0);        step();
        drv('0, 1'b0, TWO, 1'b0);        step();
        chk("mix_o21", o21, 16'hFE80);
        chk("mix_v21", v21, 1'b1);
        drv('0, 1'b0, '0, 1'b0);         step();
        chk("mix_o22", o22, 16'h0400);
        chk("mix_v22", v22, 1'b1);

        // Swap in [[2,1],[1,-0.5]] together with the first vector (1,1)
        load_w(TWO, ONE, ONE, MHALF);
        drv(ONE, 1'b1, '0, 1'b1);        step();
        drv('0, 1'b0, ONE, 1'b0);        step();
        chk("swd_o21", o21, 16'h0300);
        drv('0, 1'b0, '0, 1'b0);         step();
        chk("swd_o22", o22, 16'h0080);

        // Invalid gap between (1,0) and (0.5,2); junk data during the gap
        drv(ONE, 1'b1, '0, 1'b0);        step();
        drv(16'h0700, 1'b0, '0, 1'b0);   step();
        chk("gap_o21_a", o21, 16'h0200);
        drv(HALF, 1'b1, 16'h0500, 1'b0); step();
        chk("gap_v21_gap", v21, 1'b0);
        chk("gap_o21_gap", o21, 16'h0000);
        chk("gap_o22_a", o22, 16'h0100);
        drv('0, 1'b0, TWO, 1'b0);        step();
        chk("gap_o21_b", o21, 16'h0300);
        chk("gap_v22_gap", v22, 1'b0);
        chk("gap_o22_gap", o22, 16'h0000);
        drv('0, 1'b0, '0, 1'b0);         step();
        chk("gap_o22_b", o22, 16'hFF80);
        chk("gap_v22_b", v22, 1'b1);

        // Load identity while streaming (1,1) vectors; swap with the fourth
        wi11 = '0; wi12 = ONE; acc1 = 1'b1; acc2 = 1'b1;
        drv(ONE, 1'b1, '0, 1'b0);        step();
        wi11 = ONE; wi12 = '0;
        drv(ONE, 1'b1, ONE, 1'b0);       step();
        chk("ovl_o21_0", o21, 16'h0300);
        wi11 = '0; wi12 = '0; acc1 = 1'b0; acc2 = 1'b0;
        drv(ONE, 1'b1, ONE, 1'b0);       step();
        chk("ovl_o21_1", o21, 16'h0300);
        chk("ovl_o22_0", o22, 16'h0080);
        drv(ONE, 1'b1, ONE, 1'b1);       step();
        chk("ovl_o21_2", o21, 16'h0300);
        chk("ovl_o22_1", o22, 16'h0080);
        drv(ONE, 1'b1, ONE, 1'b0);       step();
        chk("ovl_o21_3", o21, 16'h0100);
        chk("ovl_o22_2", o22, 16'h0080);
        drv('0, 1'b0, ONE, 1'b0);        step();
        chk("ovl_o21_4", o21, 16'h0100);
        chk("ovl_o22_3", o22, 16'h0100);
        drv('0, 1'b0, '0, 1'b0);         step();
        chk("ovl_o22_4", o22, 16'h0100);
        chk("ovl_v21_end", v21, 1'b0);

        // Reset in the middle of a stream
        drv(ONE, 1'b1, '0, 1'b0);        step();
        drv(16'h0300, 1'b1, TWO, 1'b0);  step();
        drv('0, 1'b0, 16'h0400, 1'b0);   step();
        chk("mrs_v21_pre", v21, 1'b1);
        chk("mrs_v22_pre", v22, 1'b1);
        drv('0, 1'b0, '0, 1'b0);
        #2;
        rst = 1'b0;
        #1;
        chk("mrs_o21", o21, 16'h0000);
        chk("mrs_v21", v21, 1'b0);
        chk("mrs_o22", o22, 16'h0000);
        chk("mrs_v22", v22, 1'b0);
        step();
        rst = 1'b1;
        step();
        chk("mrs_v22_flush", v22, 1'b0);
        chk("mrs_o22_flush", o22, 16'h0000);
        drv(ONE, 1'b1, '0, 1'b0);        step();
        drv('0, 1'b0, ONE, 1'b0);        step();
        chk("mrs_w_clr_o21", o21, 16'h0000);
        chk("mrs_w_clr_v21", v21, 1'b1);
        drv('0, 1'b0, '0, 1'b0);         step();
        chk("mrs_w_clr_o22", o22, 16'h0000);
        chk("mrs_w_clr_v22", v22, 1'b1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/systolic.md
SYSTOLIC -- requirements
Module: systolic

Interface
REQ-001 Parameter DATA_W, default 16: operand and partial-sum width, signed two's complement.
REQ-002 Parameter FRAC_W, default 8: fractional bits; all values are Q8.8.
REQ-003 clk  input  1  single clock; all state updates on its rising edge.
REQ-004 rst  input  1  reset; asynchronous, active-low.
REQ-005 sys_data_in_11  input  16  activation stream for row 1, entering PE11.
REQ-006 sys_data_in_21  input  16  activation stream for row 2, entering PE21.
REQ-007 sys_start  input  1  valid flag for the row-1 activation in the same cycle.
REQ-008 sys_weight_in_11  input  16  weight stream for column 1, entering PE11 from the top.
REQ-009 sys_weight_in_12  input  16  weight stream for column 2, entering PE12 from the top.
REQ-010 sys_accept_w_1 / sys_accept_w_2  input  1 each  shadow-weight shift enable for column 1 / column 2.
REQ-011 sys_switch_in  input  1  shadow-to-active weight swap command, entering PE11.
REQ-012 sys_data_out_21 / sys_data_out_22  output  16 each  column-1 / column-2 partial sums leaving PE21 / PE22.
REQ-013 sys_valid_out_21 / sys_valid_out_22  output  1 each  valid for the matching data_out.

Function
REQ-014 The array SHALL be a 2x2 weight-stationary grid: PE11 PE12 on top, PE21 PE22 below.
REQ-015 Each PE SHALL hold a shadow weight and an active weight.
REQ-016 Activation, valid and switch SHALL pass right through one register per PE.
REQ-017 Shadow weight and partial sum SHALL pass down through one register per PE.
REQ-018 Top-row psum_in SHALL be 0.
REQ-019 Shadow load: when a PE's accept_w is high, its shadow register SHALL take weight_in, and its weight_out register SHALL take its previous shadow value.
REQ-020 Shadow load consequence: a column loads bottom-row weight first, top-row weight one cycle later.
REQ-021 Accept_w SHALL propagate down with the weight, so the PE below shifts on the next cycle.
REQ-022 Swap: when switch_in is high, the active register SHALL take shadow on the edge.
REQ-023 In that same cycle the multiplier SHALL use the shadow value (bypass), so data may accompany switch.
REQ-024 Switch SHALL reach PE12 and PE21 one cycle after PE11, and PE22 two cycles after PE11.
REQ-025 MAC: if valid_in, psum_out <= psum_in + (data_in * weight_eff); otherwise psum_out <= 0.
REQ-026 MAC width rule: 32-bit signed product, keep bits [23:8] (truncate), 16-bit wrapping add, no saturation.
REQ-027 Row-2 valid SHALL be sys_start delayed one cycle, matching the one-cycle skew of sys_data_in_21.
REQ-028 Valid SHALL propagate right with data and down with psum.
REQ-029 Latency: for row-1 data at cycle t and row-2 data at t+1, sys_data_out_21 = x1*W11 + x2*W21, valid at t+2.
REQ-030 Latency: sys_data_out_22 = x1*W12 + x2*W22, valid at t+3.
REQ-031 One vector per cycle SHALL stream with no bubbles.
REQ-032 Weight loads SHALL overlap computation without disturbing active weights.

Reset
REQ-033 rst low SHALL asynchronously clear all weights, partial sums, data, valid and switch registers to 0.
REQ-034 Outputs SHALL read 0 / invalid during reset and until fresh valid data propagates.
REQ-035 Reset mid-stream SHALL discard in-flight results.

Structure
REQ-036 Shared package SHALL hold the Q8.8 fixed16 type, DATA_W and FRAC_W.
REQ-037 One sub-module, pe, SHALL implement a single cell; systolic instantiates four and wires the skew.

Verification
REQ-038 Reset: assert rst=0 mid-operation -> all outputs 0 and valids 0 immediately.
REQ-039 Identity: W=[[1,0],[0,1]], vectors (1,2),(3,4) -> outputs 21/22 = 1,3 / 2,4 at t+2 / t+3.
REQ-040 Mixed: W=[[0.5,2],[-1,1]], vector (1,2) -> out_21=-1.5 (0xFE80), out_22=4.0 (0x0400).
REQ-041 Switch with data: swap to new weights in the same cycle as the first vector -> first result already uses new weights; old weights unused.
REQ-042 Invalid gaps: sys_start low for one cycle mid-stream -> matching output valid low, data 0, neighbours correct.
REQ-043 Overlap: load a second weight set while streaming, then switch -> results change exactly from the vector issued with switch.
